// File: rtl/rr_arb_mux_if.sv
// Handshake/bus bundle for rr_arb_mux: NUM_IN request channels in, one registered word out.
// The master side drives the requests and out_ready; the slave side is the arbiter/mux.
interface rr_arb_mux_if #(
    parameter int NUM_IN = 8,
    parameter int WIDTH  = 16
);
    localparam int SELW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [NUM_IN-1:0]       in_valid;
    logic [NUM_IN-1:0]       in_ready;
    logic [WIDTH-1:0]        out_data;
    logic [SELW-1:0]         out_sel;
    logic                    out_valid;
    logic                    out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_sel, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_sel, out_valid
    );
endinterface

// File: rtl/rr_arb_mux.sv
// Registered N:1 mux with round-robin arbitration and a valid/ready output stage.
// Optional macro RR_ARB_MUX_FORCE_EN adds force_en/force_sel to override the round-robin choice.
module rr_arb_mux #(
    parameter  int NUM_IN = 8,
    parameter  int WIDTH  = 16,
    localparam int SELW   = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
`ifdef RR_ARB_MUX_FORCE_EN
    input  logic            force_en,
    input  logic [SELW-1:0] force_sel,
`endif
    rr_arb_mux_if.slave     bus
);

    localparam logic [SELW:0]   NUM_IN_W = (SELW+1)'(NUM_IN);
    localparam logic [SELW-1:0] LAST_IDX = SELW'(NUM_IN - 1);

    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  out_data_q,  out_data_d;
    logic [SELW-1:0]   out_sel_q,   out_sel_d;
    logic [SELW-1:0]   rr_ptr_q,    rr_ptr_d;

    logic              rr_found_s;
    logic [SELW-1:0]   rr_idx_s;
    logic [SELW:0]     scan_s;
    logic              hit_s;
    logic              req_s;
    logic              upd_ptr_s;
    logic [SELW-1:0]   win_idx_s;
    logic [WIDTH-1:0]  win_data_s;
    logic              load_s;
    logic [NUM_IN-1:0] grant_s;

    // Round-robin search: first requesting channel at or after rr_ptr, with explicit wrap.
    always_comb begin
        rr_found_s = 1'b0;
        rr_idx_s   = '0;
        scan_s     = '0;
        hit_s      = 1'b0;
        for (int k = 0; k < NUM_IN; k++) begin
            scan_s     = {1'b0, rr_ptr_q} + (SELW+1)'(k);
            scan_s     = (scan_s >= NUM_IN_W) ? (scan_s - NUM_IN_W) : scan_s;
            hit_s      = bus.in_valid[scan_s[SELW-1:0]];
            rr_idx_s   = (!rr_found_s && hit_s) ? scan_s[SELW-1:0] : rr_idx_s;
            rr_found_s = rr_found_s | hit_s;
        end
    end

    // Winner selection; a forced pick never moves the round-robin pointer.
    always_comb begin
`ifdef RR_ARB_MUX_FORCE_EN
        if (force_en) begin
            win_idx_s = force_sel;
            req_s     = ({1'b0, force_sel} < NUM_IN_W) && bus.in_valid[force_sel];
            upd_ptr_s = 1'b0;
        end else begin
            win_idx_s = rr_idx_s;
            req_s     = rr_found_s;
            upd_ptr_s = 1'b1;
        end
`else
        win_idx_s = rr_idx_s;
        req_s     = rr_found_s;
        upd_ptr_s = 1'b1;
`endif
    end

    assign win_data_s = bus.in_data[int'(win_idx_s)*WIDTH +: WIDTH];
    assign load_s     = req_s & (~out_valid_q | bus.out_ready);

    // One-hot accept for the winner, suppressed while reset is asserted.
    always_comb begin
        grant_s = '0;
        if (load_s && rst_n) begin
            grant_s[win_idx_s] = 1'b1;
        end else begin
            grant_s = '0;
        end
    end

    // Next-state for the output stage and the round-robin pointer.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        rr_ptr_d    = rr_ptr_q;
        if (load_s) begin
            out_valid_d = 1'b1;
            out_data_d  = win_data_s;
            out_sel_d   = win_idx_s;
            if (upd_ptr_s) begin
                rr_ptr_d = (win_idx_s == LAST_IDX) ? '0 : (win_idx_s + SELW'(1));
            end else begin
                rr_ptr_d = rr_ptr_q;
            end
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers; reset discards any held word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign bus.in_ready  = grant_s;
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Self-checking bench for rr_arb_mux (NUM_IN=8, WIDTH=16): vector table, corner sequences,
// and randomized traffic against a queue-free arithmetic reference model.
`timescale 1ns/1ps
module tb_rr_arb_mux;
    localparam int NI = 8;
    localparam int W  = 16;
`ifdef RR_ARB_MUX_FORCE_EN
    localparam bit HAS_FORCE = 1'b1;
`else
    localparam bit HAS_FORCE = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       f_en  = 1'b0;
    logic [2:0] f_sel = 3'd0;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    bit          m_valid;
    logic [15:0] m_data;
    int          m_sel;
    int          m_ptr;

    typedef struct {
        logic [7:0]  vld;
        logic        rdy;
        logic [15:0] d2;
        logic [7:0]  ir;
        logic        ov;
        logic [2:0]  sel;
        logic [15:0] od;
    } vec_t;
    vec_t tbl[$];

    rr_arb_mux_if #(.NUM_IN(NI), .WIDTH(W)) bus ();

    rr_arb_mux #(.NUM_IN(NI), .WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef RR_ARB_MUX_FORCE_EN
        .force_en  (f_en),
        .force_sel (f_sel),
`endif
        .bus       (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [15:0] ch_data(input int i);
        return bus.in_data[i*W +: W];
    endfunction

    task automatic set_default_data(input logic [15:0] d2);
        for (int i = 0; i < NI; i++) bus.in_data[i*W +: W] = 16'(16'h1000 + i);
        bus.in_data[2*W +: W] = d2;
    endtask

    function automatic int model_winner();
        int g;
        g = -1;
        if (HAS_FORCE && f_en) begin
            if (int'(f_sel) < NI && bus.in_valid[f_sel]) g = int'(f_sel);
        end else begin
            for (int k = 0; k < NI; k++) begin
                int c;
                c = (m_ptr + k) % NI;
                if (g < 0 && bus.in_valid[c]) g = c;
            end
        end
        return g;
    endfunction

    function automatic logic [7:0] model_ready();
        logic [7:0] r;
        int g;
        r = 8'h00;
        g = model_winner();
        if (g >= 0 && (!m_valid || bus.out_ready)) r[g] = 1'b1;
        return r;
    endfunction

    task automatic model_edge();
        int g;
        g = model_winner();
        if (g >= 0 && (!m_valid || bus.out_ready)) begin
            m_valid = 1'b1;
            m_data  = ch_data(g);
            m_sel   = g;
            if (!(HAS_FORCE && f_en)) m_ptr = (g + 1) % NI;
        end else if (m_valid && bus.out_ready) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = 16'h0000;
        m_sel   = 0;
        m_ptr   = 0;
    endtask

    // one clock: compare against the model at the falling edge, advance the model at the rising edge
    task automatic cycle(input string tag);
        @(negedge clk);
        chk({tag, ".in_ready"},  32'(bus.in_ready),  32'(model_ready()));
        chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(m_valid));
        chk({tag, ".out_sel"},   32'(bus.out_sel),   32'(m_sel));
        chk({tag, ".out_data"},  32'(bus.out_data),  32'(m_data));
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        bus.in_valid  = 8'h00;
        bus.out_ready = 1'b0;
        bus.in_data   = '0;
        model_reset();

        // reset state, with requests present while reset is held
        bus.in_valid = 8'hFF;
        set_default_data(16'h1002);
        #12;
        chk("rst.in_ready",  32'(bus.in_ready),  32'h0);
        chk("rst.out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst.out_data",  32'(bus.out_data),  32'h0);
        chk("rst.out_sel",   32'(bus.out_sel),   32'h0);
        bus.in_valid = 8'h00;
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // vector table: round-robin sweep, single request, drain, 0/7 wrap, stall
        for (int k = 0; k < 9; k++)
            tbl.push_back('{8'hFF, 1'b1, 16'h1002, 8'(1 << (k % 8)), 1'b1, 3'(k % 8), 16'(16'h1000 + k % 8)});
        tbl.push_back('{8'h04, 1'b1, 16'hBEEF, 8'h04, 1'b1, 3'd2, 16'hBEEF});
        tbl.push_back('{8'h00, 1'b1, 16'hBEEF, 8'h00, 1'b0, 3'd2, 16'hBEEF});
        tbl.push_back('{8'h81, 1'b1, 16'h1002, 8'h80, 1'b1, 3'd7, 16'h1007});
        tbl.push_back('{8'h81, 1'b1, 16'h1002, 8'h01, 1'b1, 3'd0, 16'h1000});
        tbl.push_back('{8'h81, 1'b1, 16'h1002, 8'h80, 1'b1, 3'd7, 16'h1007});
        tbl.push_back('{8'h81, 1'b1, 16'h1002, 8'h01, 1'b1, 3'd0, 16'h1000});
        tbl.push_back('{8'h81, 1'b0, 16'h1002, 8'h00, 1'b1, 3'd0, 16'h1000});
        tbl.push_back('{8'h81, 1'b1, 16'h1002, 8'h80, 1'b1, 3'd7, 16'h1007});
        tbl.push_back('{8'h00, 1'b1, 16'h1002, 8'h00, 1'b0, 3'd7, 16'h1007});

        foreach (tbl[i]) begin
            bus.in_valid  = tbl[i].vld;
            bus.out_ready = tbl[i].rdy;
            set_default_data(tbl[i].d2);
            @(negedge clk);
            chk($sformatf("vec%0d.in_ready", i), 32'(bus.in_ready), 32'(tbl[i].ir));
            @(posedge clk);
            model_edge();
            #1;
            chk($sformatf("vec%0d.out_valid", i), 32'(bus.out_valid), 32'(tbl[i].ov));
            chk($sformatf("vec%0d.out_sel", i),   32'(bus.out_sel),   32'(tbl[i].sel));
            chk($sformatf("vec%0d.out_data", i),  32'(bus.out_data),  32'(tbl[i].od));
        end

        // backpressure: hold ch3 word for 5 stalled cycles while ch5 requests
        set_default_data(16'h1002);
        bus.in_data[3*W +: W] = 16'h00AA;
        bus.in_valid  = 8'h08;
        bus.out_ready = 1'b1;
        cycle("bp.load");
        chk("bp.loaded_data", 32'(bus.out_data), 32'h00AA);
        bus.in_valid  = 8'h20;
        bus.out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            cycle("bp.stall");
            chk("bp.hold_data",  32'(bus.out_data),  32'h00AA);
            chk("bp.hold_sel",   32'(bus.out_sel),   32'h3);
            chk("bp.hold_valid", 32'(bus.out_valid), 32'h1);
            chk("bp.no_ready",   32'(bus.in_ready),  32'h0);
        end
        bus.out_ready = 1'b1;
        #1 chk("bp.release_ready", 32'(bus.in_ready), 32'h20);
        cycle("bp.release");
        chk("bp.release_sel", 32'(bus.out_sel), 32'h5);

        // asynchronous reset while a stalled word is held
        bus.out_ready = 1'b0;
        bus.in_valid  = 8'h20;
        cycle("rs.stall");
        #2 rst_n = 1'b0;
        #1;
        chk("rs.out_valid", 32'(bus.out_valid), 32'h0);
        chk("rs.out_data",  32'(bus.out_data),  32'h0);
        chk("rs.in_ready",  32'(bus.in_ready),  32'h0);
        model_reset();
        bus.in_valid = 8'h00;
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;
        bus.in_valid  = 8'hFF;
        bus.out_ready = 1'b1;
        cycle("rs.restart");
        chk("rs.restart_sel", 32'(bus.out_sel), 32'h0);

`ifdef RR_ARB_MUX_FORCE_EN
        // forced select: ch6 every cycle, then no load when ch6 is idle, pointer untouched
        f_en  = 1'b1;
        f_sel = 3'd6;
        for (int c = 0; c < 3; c++) begin
            cycle("fx.force");
            chk("fx.sel", 32'(bus.out_sel), 32'h6);
        end
        bus.in_valid = 8'hBF;
        #1 chk("fx.idle_ready", 32'(bus.in_ready), 32'h0);
        cycle("fx.idle");
        chk("fx.idle_valid", 32'(bus.out_valid), 32'h0);
        f_en = 1'b0;
        bus.in_valid = 8'hFF;
        cycle("fx.resume");
        chk("fx.resume_sel", 32'(bus.out_sel), 32'h1);
`endif

        // randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            bus.in_valid  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NI; i++) bus.in_data[i*W +: W] = 16'($urandom);
            if (HAS_FORCE) begin
                f_en  = ($urandom_range(0, 4) == 0);
                f_sel = 3'($urandom_range(0, 7));
            end
            cycle("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
